// File: rtl/obj_det_gen.sv
// obj_det_gen: per-frame object-presence detector on the sensor pixel bus.
// Drives the IR strobe for lit frames, counts bright pixels inside a fixed
// ROI and issues one presence decision plus a one-cycle qualifier per frame.
// Optional build macro AMBIENT_SUB_EN: subtract the last unlit frame's count
// from each lit frame's count before thresholding.
module obj_det_gen #(
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 9,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ROI_X0     = 40,
  parameter int unsigned ROI_X1     = 279,
  parameter int unsigned ROI_Y0     = 20,
  parameter int unsigned ROI_Y1     = 219,
  parameter logic [7:0]  PIX_TH     = 8'd128,
  parameter int unsigned DET_TH_ACQ = 600,
  parameter int unsigned DET_TH_TRK = 300
) (
  input  logic             pclk,
  input  logic             resetn,
  input  logic             i_fv,
  input  logic             i_lv,
  input  logic [7:0]       i_pix,
  input  logic             i_en_strobe,
  input  logic             i_search_mode,
  output logic             o_strobe,
  output logic             o_obj_det,
  output logic             o_obj_det_trig,
  output logic [CNT_W-1:0] o_bright_cnt
);

  typedef enum logic [1:0] {SYNC, IDLE, FRAME, EVAL} state_t;

  state_t           state;
  logic             fv_d;
  logic             lv_d;
  logic             frame_lit;
  logic             thr_sel;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [CNT_W-1:0] cnt;

  logic             fv_rise;
  logic             fv_fall;
  logic             lv_fall;
  logic             pix_vld;
  logic             in_roi;
  logic             bright;
  logic [CNT_W-1:0] det_thr;
  logic [CNT_W-1:0] eval_cnt;

  assign fv_rise = i_fv & ~fv_d;
  assign fv_fall = ~i_fv & fv_d;
  assign lv_fall = ~i_lv & lv_d;
  assign pix_vld = i_fv & i_lv;
  assign in_roi  = (x >= X_W'(ROI_X0)) && (x <= X_W'(ROI_X1)) &&
                   (y >= Y_W'(ROI_Y0)) && (y <= Y_W'(ROI_Y1));
  assign bright  = pix_vld && in_roi && (i_pix >= PIX_TH);
  assign det_thr = thr_sel ? CNT_W'(DET_TH_ACQ) : CNT_W'(DET_TH_TRK);

`ifdef AMBIENT_SUB_EN
  logic [CNT_W-1:0] amb_cnt;

  // Lit frames are judged on their excess over the last unlit (ambient) frame.
  assign eval_cnt = !frame_lit ? cnt :
                    (cnt > amb_cnt) ? (cnt - amb_cnt) : '0;

  // Capture the ambient count when an unlit frame is evaluated.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      amb_cnt <= '0;
    end else if (state == FRAME && fv_fall && !frame_lit) begin
      amb_cnt <= cnt;
    end
  end
`else
  assign eval_cnt = cnt;
`endif

  // One-cycle delayed frame/line valid for edge detection.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      fv_d <= 1'b0;
      lv_d <= 1'b0;
    end else begin
      fv_d <= i_fv;
      lv_d <= i_lv;
    end
  end

  // Frame FSM with pixel counting and registered decision outputs.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state          <= SYNC;
      frame_lit      <= 1'b0;
      thr_sel        <= 1'b0;
      x              <= '0;
      y              <= '0;
      cnt            <= '0;
      o_strobe       <= 1'b0;
      o_obj_det      <= 1'b0;
      o_obj_det_trig <= 1'b0;
      o_bright_cnt   <= '0;
    end else begin
      o_obj_det_trig <= 1'b0;
      case (state)
        // Skip any frame already in progress when reset was released.
        SYNC: begin
          if (!i_fv) state <= IDLE;
        end
        IDLE: begin
          if (fv_rise) begin
            frame_lit <= i_en_strobe;
            thr_sel   <= i_search_mode;
            x         <= '0;
            y         <= '0;
            cnt       <= '0;
            o_strobe  <= i_en_strobe;
            state     <= FRAME;
          end
        end
        FRAME: begin
          if (fv_fall) begin
            o_strobe       <= 1'b0;
            o_obj_det_trig <= 1'b1;
            o_obj_det      <= frame_lit && (eval_cnt >= det_thr);
            o_bright_cnt   <= eval_cnt;
            state          <= EVAL;
          end else begin
            if (pix_vld && (x != '1)) x <= x + X_W'(1);
            if (lv_fall) begin
              x <= '0;
              if (y != '1) y <= y + Y_W'(1);
            end
            if (bright && (cnt != '1)) cnt <= cnt + CNT_W'(1);
          end
        end
        EVAL: begin
          state <= IDLE;
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_obj_det_gen.sv
// Directed bench for obj_det_gen: frames are synthesised row by row, a
// geometric model predicts each frame's decision, and a monitor pops the
// scoreboard on every trigger pulse.
module tb_obj_det_gen;

  typedef struct packed {
    logic        det;
    logic [15:0] cnt;
  } exp_t;

  logic        pclk = 1'b0;
  logic        resetn;
  logic        i_fv;
  logic        i_lv;
  logic [7:0]  i_pix;
  logic        i_en_strobe;
  logic        i_search_mode;
  logic        o_strobe;
  logic        o_obj_det;
  logic        o_obj_det_trig;
  logic [15:0] o_bright_cnt;

  int   checks = 0;
  int   errors = 0;
  int   n_trig = 0;
  int   n_exp  = 0;
  exp_t sb[$];
`ifdef AMBIENT_SUB_EN
  int   amb = 0;
`endif

  obj_det_gen dut (
    .pclk           (pclk),
    .resetn         (resetn),
    .i_fv           (i_fv),
    .i_lv           (i_lv),
    .i_pix          (i_pix),
    .i_en_strobe    (i_en_strobe),
    .i_search_mode  (i_search_mode),
    .o_strobe       (o_strobe),
    .o_obj_det      (o_obj_det),
    .o_obj_det_trig (o_obj_det_trig),
    .o_bright_cnt   (o_bright_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: each trigger must match the oldest expected frame.
  always @(negedge pclk) begin
    exp_t e;
    if (o_obj_det_trig === 1'b1) begin
      n_trig++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_trig observed trigger expected none (scoreboard empty)");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("obj_det", 32'(o_obj_det), 32'(e.det));
        chk("bright_cnt", 32'(o_bright_cnt), 32'(e.cnt));
      end
    end
  end

  // Rows below y0 carry one dark pixel; from y0 on, full rows of xh+1 pixels
  // with up to nb pixels of value val placed at columns >= xl.
  task automatic run_frame(input logic en, input logic sm, input int y0,
                           input int xl, input int xh, input int nb,
                           input logic [7:0] val);
    int   left;
    int   y;
    int   raw;
    int   ev;
    int   last;
    exp_t e;
    left = nb;
    y    = 0;
    raw  = 0;
    i_en_strobe   = en;
    i_search_mode = sm;
    @(negedge pclk);
    i_fv = 1'b1;
    repeat (3) @(negedge pclk);
    chk("strobe_on", 32'(o_strobe), 32'(en));
    i_en_strobe   = ~en;
    i_search_mode = ~sm;
    while (y < y0 || left > 0) begin
      last = (y < y0) ? 0 : xh;
      for (int x = 0; x <= last; x++) begin
        i_lv = 1'b1;
        if (y >= y0 && x >= xl && left > 0) begin
          i_pix = val;
          left--;
          if (y >= 20 && y <= 219 && x >= 40 && x <= 279 && val >= 8'd128) raw++;
        end else begin
          i_pix = 8'd0;
        end
        @(negedge pclk);
      end
      i_lv  = 1'b0;
      i_pix = 8'd0;
      repeat (2) @(negedge pclk);
      y++;
    end
    ev = raw;
`ifdef AMBIENT_SUB_EN
    if (!en) amb = raw;
    else ev = (raw > amb) ? raw - amb : 0;
`endif
    e.det = en && (ev >= (sm ? 600 : 300));
    e.cnt = 16'(ev);
    sb.push_back(e);
    n_exp++;
    chk("strobe_hold", 32'(o_strobe), 32'(en));
    i_fv = 1'b0;
    @(negedge pclk);
    chk("trig_hi", 32'(o_obj_det_trig), 32'd1);
    chk("strobe_off", 32'(o_strobe), 32'd0);
    @(negedge pclk);
    chk("trig_lo", 32'(o_obj_det_trig), 32'd0);
    repeat (3) @(negedge pclk);
    chk("trig_count", 32'(n_trig), 32'(n_exp));
  endtask

  initial begin
    resetn        = 1'b0;
    i_fv          = 1'b1;
    i_lv          = 1'b0;
    i_pix         = 8'd0;
    i_en_strobe   = 1'b1;
    i_search_mode = 1'b1;

    // Reset with a frame in progress: outputs at reset values.
    repeat (3) @(negedge pclk);
    chk("rst_strobe", 32'(o_strobe), 32'd0);
    chk("rst_det", 32'(o_obj_det), 32'd0);
    chk("rst_trig", 32'(o_obj_det_trig), 32'd0);
    chk("rst_cnt", 32'(o_bright_cnt), 32'd0);
    resetn = 1'b1;

    // Tail of the partial frame, then fv falls: no trigger allowed.
    for (int i = 0; i < 6; i++) begin
      i_lv  = 1'(i % 2);
      i_pix = 8'd255;
      @(negedge pclk);
    end
    i_lv  = 1'b0;
    i_pix = 8'd0;
    i_fv  = 1'b0;
    repeat (6) @(negedge pclk);
    chk("partial_no_trig", 32'(n_trig), 32'd0);
    chk("partial_strobe", 32'(o_strobe), 32'd0);

    // Lit acquisition frame, 700 bright ROI pixels.
    run_frame(1'b1, 1'b1, 20, 40, 279, 700, 8'd200);
    // Same content unlit.
    run_frame(1'b0, 1'b1, 20, 40, 279, 700, 8'd200);
    // Tracking threshold vs acquisition threshold at 350.
    run_frame(1'b1, 1'b0, 20, 40, 279, 350, 8'd200);
    run_frame(1'b1, 1'b1, 20, 40, 279, 350, 8'd200);
    // Bright pixels just outside the ROI.
    run_frame(1'b1, 1'b0, 20, 280, 280, 5, 8'd255);
    run_frame(1'b1, 1'b0, 19, 40, 279, 240, 8'd255);
    // Pixel threshold boundary.
    run_frame(1'b1, 1'b0, 20, 40, 279, 10, 8'd127);
    run_frame(1'b1, 1'b0, 20, 40, 279, 10, 8'd128);
    // Ambient frame followed by lit frame.
    run_frame(1'b0, 1'b1, 20, 40, 279, 400, 8'd200);
    run_frame(1'b1, 1'b1, 20, 40, 279, 900, 8'd200);

    // Reset mid-frame: immediate clear, frame discarded.
    i_en_strobe = 1'b1;
    @(negedge pclk);
    i_fv = 1'b1;
    repeat (3) @(negedge pclk);
    chk("mid_strobe_on", 32'(o_strobe), 32'd1);
    i_lv  = 1'b1;
    i_pix = 8'd255;
    repeat (4) @(negedge pclk);
    resetn = 1'b0;
    #1;
    chk("mid_rst_strobe", 32'(o_strobe), 32'd0);
    chk("mid_rst_det", 32'(o_obj_det), 32'd0);
    chk("mid_rst_cnt", 32'(o_bright_cnt), 32'd0);
`ifdef AMBIENT_SUB_EN
    amb = 0;
`endif
    @(negedge pclk);
    resetn = 1'b1;
    repeat (4) @(negedge pclk);
    i_lv  = 1'b0;
    i_pix = 8'd0;
    i_fv  = 1'b0;
    repeat (6) @(negedge pclk);
    chk("mid_no_trig", 32'(n_trig), 32'(n_exp));

    // Normal operation resumes after the discarded frame.
    run_frame(1'b1, 1'b0, 20, 40, 279, 300, 8'd150);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
